// File: rtl/shl_seq_unit.sv
// shl_seq_unit: sequential 3-stage logarithmic left shifter/rotator.
// One stage per clock (by 1, by 2, by 4), each enabled by one bit of the
// captured shift amount. Mode selects logical (zero fill) or rotate left.
// Optional build macro SHL_SKIP_EN: stages whose amount bit is 0 are
// skipped (the final by-4 stage always runs), shortening latency to
// 1 + popcount(sel[1:0]) cycles. Results are identical in both builds.
module shl_seq_unit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] in,
    input  logic [2:0] sel,
    input  logic       mode,
    output logic [7:0] out,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ST1  = 2'd1,
        ST2  = 2'd2,
        ST4  = 2'd3
    } state_t;

    state_t      state_q;
    logic [7:0]  acc_q;
    logic [7:0]  acc_d;
    logic [2:0]  amt_q;
    logic        md_q;
    logic [7:0]  out_q;
    logic        busy_q;
    logic        done_q;
    state_t      accept_nxt_s;
    state_t      st1_nxt_s;

    // One shifter stage: shift v left by k when en, wrapping bits into the
    // bottom when rot is set, otherwise zero filling.
    function automatic logic [7:0] shl_stage(
        input logic [7:0] v,
        input logic [2:0] k,
        input logic       rot,
        input logic       en
    );
        logic [15:0] w;
        logic [7:0]  r;
        w = {8'h00, v} << k;
        if (!en) begin
            r = v;
        end else if (rot) begin
            r = w[7:0] | w[15:8];
        end else begin
            r = w[7:0];
        end
        return r;
    endfunction

    // Datapath: value the current stage writes back into the accumulator.
    always_comb begin
        acc_d = acc_q;
        case (state_q)
            ST1:     acc_d = shl_stage(acc_q, 3'd1, md_q, amt_q[0]);
            ST2:     acc_d = shl_stage(acc_q, 3'd2, md_q, amt_q[1]);
            ST4:     acc_d = shl_stage(acc_q, 3'd4, md_q, amt_q[2]);
            default: acc_d = acc_q;
        endcase
    end

    // Stage sequencing: first stage after accept and successor of ST1.
    always_comb begin
`ifdef SHL_SKIP_EN
        if (sel[0]) begin
            accept_nxt_s = ST1;
        end else if (sel[1]) begin
            accept_nxt_s = ST2;
        end else begin
            accept_nxt_s = ST4;
        end
        if (amt_q[1]) begin
            st1_nxt_s = ST2;
        end else begin
            st1_nxt_s = ST4;
        end
`else
        accept_nxt_s = ST1;
        st1_nxt_s    = ST2;
`endif
    end

    // Control FSM with registered out/busy/done; start is ignored unless IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= 8'h00;
            amt_q   <= 3'd0;
            md_q    <= 1'b0;
            out_q   <= 8'h00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        acc_q   <= in;
                        amt_q   <= sel;
                        md_q    <= mode;
                        busy_q  <= 1'b1;
                        state_q <= accept_nxt_s;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                ST1: begin
                    acc_q   <= acc_d;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b1;
                    state_q <= st1_nxt_s;
                end
                ST2: begin
                    acc_q   <= acc_d;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b1;
                    state_q <= ST4;
                end
                ST4: begin
                    acc_q   <= acc_d;
                    out_q   <= acc_d;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign out  = out_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_shl_seq_unit.sv
// Testbench for shl_seq_unit: directed scenarios plus randomized operations
// checked against an arithmetic reference model.
module tb_shl_seq_unit;

    logic       clk;
    logic       rst_n;
    logic       start_r;
    logic [7:0] in_r;
    logic [2:0] sel_r;
    logic       mode_r;
    logic [7:0] out_w;
    logic       busy_w;
    logic       done_w;

    int         n_pass;
    int         n_total;
    logic [7:0] last_out;

    shl_seq_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start_r),
        .in    (in_r),
        .sel   (sel_r),
        .mode  (mode_r),
        .out   (out_w),
        .busy  (busy_w),
        .done  (done_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: multiply by 2^s; logical keeps the low byte, rotate adds
    // the overflow byte back in at the bottom.
    function automatic logic [7:0] ref_shl(input logic [7:0] a, input int s, input bit rot);
        int v;
        int r;
        v = int'(a) * (1 << s);
        if (rot) r = (v % 256) + (v / 256);
        else     r = v % 256;
        return 8'(r);
    endfunction

    // Reference latency in cycles from accept edge to done.
    function automatic int ref_lat(input logic [2:0] s);
`ifdef SHL_SKIP_EN
        return 1 + int'(s[0]) + int'(s[1]);
`else
        return 3;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Drive a request at the current negedge; returns at the next negedge.
    task automatic issue(input logic [7:0] a, input logic [2:0] s, input logic m);
        start_r = 1'b1;
        in_r    = a;
        sel_r   = s;
        mode_r  = m;
        @(negedge clk);
        start_r = 1'b0;
        in_r    = 8'($urandom_range(0, 255));
        sel_r   = 3'($urandom_range(0, 7));
        mode_r  = 1'($urandom_range(0, 1));
    endtask

    // Wait (bounded) for done; k0 = cycles already elapsed since accept.
    task automatic finish_op(input string tag, input logic [7:0] exp_out, input int exp_lat, input int k0);
        int k;
        k = k0;
        while (done_w !== 1'b1 && k < 10) begin
            chk({tag, "_busy"}, 32'(busy_w), 32'd1);
            chk({tag, "_hold"}, 32'(out_w), 32'(last_out));
            @(negedge clk);
            k = k + 1;
        end
        chk({tag, "_done"}, 32'(done_w), 32'd1);
        chk({tag, "_lat"}, 32'(k), 32'(exp_lat));
        chk({tag, "_out"}, 32'(out_w), 32'(exp_out));
        chk({tag, "_busy_end"}, 32'(busy_w), 32'd0);
        last_out = exp_out;
    endtask

    // Full operation followed by a check that done lasted one cycle.
    task automatic op(input string tag, input logic [7:0] a, input logic [2:0] s, input logic m);
        issue(a, s, m);
        finish_op(tag, ref_shl(a, int'(s), m), ref_lat(s), 0);
        @(negedge clk);
        chk({tag, "_pulse"}, 32'(done_w), 32'd0);
        chk({tag, "_keep"}, 32'(out_w), 32'(last_out));
    endtask

    initial begin
        logic [7:0] ra;
        logic [2:0] rs;
        logic       rm;
        n_pass   = 0;
        n_total  = 0;
        last_out = 8'h00;
        rst_n    = 1'b0;
        start_r  = 1'b0;
        in_r     = 8'h00;
        sel_r    = 3'd0;
        mode_r   = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out", 32'(out_w), 32'h00);
        chk("rst_busy", 32'(busy_w), 32'd0);
        chk("rst_done", 32'(done_w), 32'd0);
        rst_n = 1'b1;

        // First accept right on the first edge after reset release.
        op("d96_l", 8'h96, 3'd3, 1'b0);
        chk("d96_l_val", 32'(last_out), 32'hB0);
        op("d96_r", 8'h96, 3'd3, 1'b1);
        op("d81_r", 8'h81, 3'd7, 1'b1);
        op("dFF_l", 8'hFF, 3'd7, 1'b0);
        op("d5A_0", 8'h5A, 3'd0, 1'b0);

        // Start while busy is ignored; start in the done cycle is accepted.
        issue(8'h01, 3'd1, 1'b0);
        start_r = 1'b1;
        in_r    = 8'hFF;
        sel_r   = 3'd7;
        mode_r  = 1'b1;
        @(negedge clk);
        start_r = 1'b0;
        finish_op("ign", 8'h02, ref_lat(3'd1), 1);
        issue(8'h12, 3'd4, 1'b1);
        chk("b2b_busy", 32'(busy_w), 32'd1);
        chk("b2b_nodone", 32'(done_w), 32'd0);
        finish_op("b2b", 8'h21, ref_lat(3'd4), 0);
        @(negedge clk);

        // Reset while in ST2 aborts the operation.
        issue(8'hF0, 3'd7, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_out", 32'(out_w), 32'h00);
        chk("abort_busy", 32'(busy_w), 32'd0);
        chk("abort_done", 32'(done_w), 32'd0);
        last_out = 8'h00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_quiet", 32'(done_w), 32'd0);
        end
        rst_n = 1'b1;
        op("post_rst", 8'h03, 3'd2, 1'b0);
        chk("post_rst_val", 32'(last_out), 32'h0C);

        // Randomized operations with random idle gaps.
        for (int n = 0; n < 40; n++) begin
            ra = 8'($urandom_range(0, 255));
            rs = 3'($urandom_range(0, 7));
            rm = 1'($urandom_range(0, 1));
            op("rnd", ra, rs, rm);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
